// File: rtl/id_ex_hazard_ctrl_if.sv
// ID-stage hazard bus: decoded ID operands in, pipeline hold/bubble/flush and EX forward selects out.
// The master drives the decoded ID instruction; the slave is the hazard controller.
interface id_ex_hazard_ctrl_if #(
    parameter int REG_AW = 3
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_write;
    logic              id_is_load;
    logic              ex_branch_taken;
    logic              stall_if;
    logic              bubble_ex;
    logic              flush_id;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              state;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs2_used, id_rd, id_write, id_is_load,
               ex_branch_taken,
        input  stall_if, bubble_ex, flush_id, fwd_a, fwd_b, state
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs2_used, id_rd, id_write, id_is_load,
               ex_branch_taken,
        output stall_if, bubble_ex, flush_id, fwd_a, fwd_b, state
    );
endinterface

// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX hazard controller: shadows EX/MEM/WB destinations, drives stall/bubble/flush and EX forwarding.
// Define ID_EX_HAZARD_FWD_EN for forwarding (load-use stalls only); otherwise stalls last until WB drains.
module id_ex_hazard_ctrl #(
    parameter int REG_AW       = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input logic                 clk,
    input logic                 reset,
    id_ex_hazard_ctrl_if.slave  hz
);

    localparam int CNT_W = 3;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              write;
        logic              load;
    } slot_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    slot_t            ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall_c, bubble_c, flush_c;
    logic             hazard;
    logic             unused_wb;

    function automatic logic writes(input slot_t s, input logic [REG_AW-1:0] r);
        return s.valid && s.write && (s.rd == r) && (r != '0);
    endfunction

`ifdef ID_EX_HAZARD_FWD_EN
    logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

    // EX slot is one instruction ahead, so it forwards from EX/MEM once the consumer reaches EX.
    function automatic logic [1:0] fwd_sel(input slot_t ex_s, input slot_t mem_s,
                                           input logic [REG_AW-1:0] r);
        if (writes(ex_s, r))  return 2'b01;
        if (writes(mem_s, r)) return 2'b10;
        return 2'b00;
    endfunction

    always_comb begin
        hazard = ex_q.load && (writes(ex_q, hz.id_rs1) ||
                               (hz.id_rs2_used && writes(ex_q, hz.id_rs2)));
    end

    always_comb begin
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
        if (!bubble_c) begin
            fwd_a_d = fwd_sel(ex_q, mem_q, hz.id_rs1);
            if (hz.id_rs2_used) fwd_b_d = fwd_sel(ex_q, mem_q, hz.id_rs2);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign hz.fwd_a = fwd_a_q;
    assign hz.fwd_b = fwd_b_q;
`else
    always_comb begin
        hazard = writes(ex_q, hz.id_rs1) || writes(mem_q, hz.id_rs1) || writes(wb_q, hz.id_rs1) ||
                 (hz.id_rs2_used && (writes(ex_q, hz.id_rs2) || writes(mem_q, hz.id_rs2) ||
                                     writes(wb_q, hz.id_rs2)));
    end

    assign hz.fwd_a = 2'b00;
    assign hz.fwd_b = 2'b00;
`endif

    // The WB load flag is tracked for symmetry but never affects a decision.
    assign unused_wb = ^wb_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_c  = 1'b0;
        bubble_c = 1'b0;
        flush_c  = 1'b0;
        case (state_q)
            RUN: begin
                if (hz.ex_branch_taken) begin
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                    cnt_d    = CNT_W'(FLUSH_CYCLES - 1);
                    state_d  = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                end else if (hazard && hz.id_valid) begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                end
            end
            FLUSH: begin
                // Branches are ignored here: EX holds only bubbles.
                flush_c  = 1'b1;
                bubble_c = 1'b1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        mem_d = ex_q;
        wb_d  = mem_q;
        ex_d  = '0;
        if (!bubble_c) begin
            ex_d.valid = hz.id_valid;
            ex_d.rd    = hz.id_rd;
            ex_d.write = hz.id_write;
            ex_d.load  = hz.id_is_load;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz.stall_if  = stall_c  & ~reset;
    assign hz.bubble_ex = bubble_c & ~reset;
    assign hz.flush_id  = flush_c  & ~reset;
    assign hz.state     = state_q;

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Bench for id_ex_hazard_ctrl: per-cycle vector table with a scoreboard queue, plus reset/flush sequences.
// Expected tables follow the same ID_EX_HAZARD_FWD_EN setting as the design build.
module tb_id_ex_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_ex_hazard_ctrl_if #(.REG_AW(3)) bus_a ();
    id_ex_hazard_ctrl_if #(.REG_AW(3)) bus_b ();

    id_ex_hazard_ctrl #(.REG_AW(3), .FLUSH_CYCLES(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .hz    (bus_a.slave)
    );

    id_ex_hazard_ctrl #(.REG_AW(3), .FLUSH_CYCLES(3)) dut_b (
        .clk   (clk),
        .reset (reset),
        .hz    (bus_b.slave)
    );

    // Expected output word: {stall_if, bubble_ex, flush_id, state, fwd_a[1:0], fwd_b[1:0]}
    typedef struct {
        logic       v;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic       u2;
        logic [2:0] rd;
        logic       w;
        logic       ld;
        logic       br;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic add_vec(input logic v, input logic [2:0] rs1, input logic [2:0] rs2,
                           input logic u2, input logic [2:0] rd, input logic w, input logic ld,
                           input logic br, input logic st, input logic bu, input logic fl,
                           input logic sm, input logic [1:0] fa, input logic [1:0] fb);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.u2 = u2; t.rd = rd;
        t.w = w; t.ld = ld; t.br = br;
        t.exp = {st, bu, fl, sm, fa, fb};
        vecs.push_back(t);
    endtask

    task automatic drive_a(input vec_t t);
        bus_a.id_valid        = t.v;
        bus_a.id_rs1          = t.rs1;
        bus_a.id_rs2          = t.rs2;
        bus_a.id_rs2_used     = t.u2;
        bus_a.id_rd           = t.rd;
        bus_a.id_write        = t.w;
        bus_a.id_is_load      = t.ld;
        bus_a.ex_branch_taken = t.br;
    endtask

    task automatic drive_b(input logic v, input logic [2:0] rd, input logic br);
        bus_b.id_valid        = v;
        bus_b.id_rs1          = 3'd0;
        bus_b.id_rs2          = 3'd0;
        bus_b.id_rs2_used     = 1'b1;
        bus_b.id_rd           = rd;
        bus_b.id_write        = v;
        bus_b.id_is_load      = 1'b0;
        bus_b.ex_branch_taken = br;
    endtask

    function automatic logic [7:0] obs_a();
        return {bus_a.stall_if, bus_a.bubble_ex, bus_a.flush_id, bus_a.state, bus_a.fwd_a, bus_a.fwd_b};
    endfunction

    function automatic logic [7:0] obs_b();
        return {bus_b.stall_if, bus_b.bubble_ex, bus_b.flush_id, bus_b.state, bus_b.fwd_a, bus_b.fwd_b};
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (stall,bubble,flush,state,fwd_a,fwd_b)",
                     name, got, want);
        end
    endtask

    initial begin
        vec_t       idle;
        logic [7:0] want;

        idle.v = 0; idle.rs1 = 0; idle.rs2 = 0; idle.u2 = 0; idle.rd = 0;
        idle.w = 0; idle.ld = 0; idle.br = 0; idle.exp = 8'h00;

`ifdef ID_EX_HAZARD_FWD_EN
        // add x1 ; add x2,x1,x3 -> EX/MEM forward
        add_vec(1,2,3,1,1,1,0,0, 0,0,0,0,2'b00,2'b00);
        add_vec(1,1,3,1,2,1,0,0, 0,0,0,0,2'b00,2'b00);
        add_vec(0,0,0,0,0,0,0,0, 0,0,0,0,2'b01,2'b00);
        // add x4 ; add x5 ; add x6,x4,x0 -> MEM/WB forward
        add_vec(1,0,0,1,4,1,0,0, 0,0,0,0,2'b00,2'b00);
        add_vec(1,0,0,1,5,1,0,0, 0,0,0,0,2'b00,2'b00);
        add_vec(1,4,0,1,6,1,0,0, 0,0,0,0,2'b00,2'b00);
        add_vec(0,0,0,0,0,0,0,0, 0,0,0,0,2'b10,2'b00);
        // load to x0 then read x0
        add_vec(1,0,0,1,0,1,1,0, 0,0,0,0,2'b00,2'b00);
        add_vec(1,0,0,1,7,1,0,0, 0,0,0,0,2'b00,2'b00);
        add_vec(0,0,0,0,0,0,0,0, 0,0,0,0,2'b00,2'b00);
        // lw x4 ; add x5,x4,x4 -> one stall, then both forwarded from MEM/WB
        add_vec(1,1,0,0,4,1,1,0, 0,0,0,0,2'b00,2'b00);
        add_vec(1,4,4,1,5,1,0,0, 1,1,0,0,2'b00,2'b00);
        add_vec(1,4,4,1,5,1,0,0, 0,0,0,0,2'b00,2'b00);
        add_vec(0,0,0,0,0,0,0,0, 0,0,0,0,2'b10,2'b10);
        // lw x3 ; dependent add with taken branch -> flush wins, two flush cycles
        add_vec(1,0,0,0,3,1,1,0, 0,0,0,0,2'b00,2'b00);
        add_vec(1,3,0,1,6,1,0,1, 0,1,1,0,2'b00,2'b00);
        add_vec(0,0,0,0,0,0,0,1, 0,1,1,1,2'b00,2'b00);
        add_vec(0,0,0,0,0,0,0,0, 0,0,0,0,2'b00,2'b00);
`else
        // add x1 ; add x2,x1,x3 -> stalls until x1 leaves WB
        add_vec(1,2,3,1,1,1,0,0, 0,0,0,0,2'b00,2'b00);
        add_vec(1,1,3,1,2,1,0,0, 1,1,0,0,2'b00,2'b00);
        add_vec(1,1,3,1,2,1,0,0, 1,1,0,0,2'b00,2'b00);
        add_vec(1,1,3,1,2,1,0,0, 1,1,0,0,2'b00,2'b00);
        add_vec(1,1,3,1,2,1,0,0, 0,0,0,0,2'b00,2'b00);
        add_vec(0,0,0,0,0,0,0,0, 0,0,0,0,2'b00,2'b00);
        // add x4 ; add x5 ; add x6,x4,x0 -> two stalls
        add_vec(1,0,0,1,4,1,0,0, 0,0,0,0,2'b00,2'b00);
        add_vec(1,0,0,1,5,1,0,0, 0,0,0,0,2'b00,2'b00);
        add_vec(1,4,0,1,6,1,0,0, 1,1,0,0,2'b00,2'b00);
        add_vec(1,4,0,1,6,1,0,0, 1,1,0,0,2'b00,2'b00);
        add_vec(1,4,0,1,6,1,0,0, 0,0,0,0,2'b00,2'b00);
        add_vec(0,0,0,0,0,0,0,0, 0,0,0,0,2'b00,2'b00);
        // load to x0 then read x0
        add_vec(1,0,0,1,0,1,1,0, 0,0,0,0,2'b00,2'b00);
        add_vec(1,0,0,1,7,1,0,0, 0,0,0,0,2'b00,2'b00);
        add_vec(0,0,0,0,0,0,0,0, 0,0,0,0,2'b00,2'b00);
        // lw x4 ; add x5,x4,x4 -> three stalls
        add_vec(1,1,0,0,4,1,1,0, 0,0,0,0,2'b00,2'b00);
        add_vec(1,4,4,1,5,1,0,0, 1,1,0,0,2'b00,2'b00);
        add_vec(1,4,4,1,5,1,0,0, 1,1,0,0,2'b00,2'b00);
        add_vec(1,4,4,1,5,1,0,0, 1,1,0,0,2'b00,2'b00);
        add_vec(1,4,4,1,5,1,0,0, 0,0,0,0,2'b00,2'b00);
        add_vec(0,0,0,0,0,0,0,0, 0,0,0,0,2'b00,2'b00);
        // lw x3 ; dependent add with taken branch -> flush wins, two flush cycles
        add_vec(1,0,0,0,3,1,1,0, 0,0,0,0,2'b00,2'b00);
        add_vec(1,3,0,1,6,1,0,1, 0,1,1,0,2'b00,2'b00);
        add_vec(0,0,0,0,0,0,0,1, 0,1,1,1,2'b00,2'b00);
        add_vec(0,0,0,0,0,0,0,0, 0,0,0,0,2'b00,2'b00);
`endif

        // Reset held with a taken branch pending: control outputs must stay low.
        reset = 1'b1;
        drive_a(idle);
        bus_a.ex_branch_taken = 1'b1;
        drive_b(1'b0, 3'd0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_a", obs_a(), 8'h00);
        check("reset_b", obs_b(), 8'h00);
        drive_a(idle);
        drive_b(1'b0, 3'd0, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive_a(vecs[i]);
            sb.push_back(vecs[i].exp);
            #1;
            want = sb.pop_front();
            check($sformatf("vec%0d", i), obs_a(), want);
        end

        // FLUSH_CYCLES=3 instance: reset after one FLUSH cycle aborts the flush.
        @(negedge clk);
        drive_a(idle);
        drive_b(1'b0, 3'd0, 1'b1);
        #1;
        check("b_branch", obs_b(), 8'b0110_0000);
        @(negedge clk);
        drive_b(1'b0, 3'd0, 1'b0);
        #1;
        check("b_flush_state", obs_b(), 8'b0111_0000);
        reset = 1'b1;
        #1;
        check("b_reset_held", obs_b(), 8'h00);
        @(negedge clk);
        #1;
        check("b_after_reset_edge", obs_b(), 8'h00);
        reset = 1'b0;
        @(negedge clk);
        drive_b(1'b1, 3'd1, 1'b0);
        #1;
        check("b_independent_insn", obs_b(), 8'h00);
        @(negedge clk);
        drive_b(1'b0, 3'd0, 1'b0);
        #1;
        check("b_next_cycle", obs_b(), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_ctrl.md
# id_ex_hazard_ctrl

Pipeline hazard controller for the 8-bit, 8-register RISC-V core. It sequences the ID/EX pipeline register. It tracks the destination registers of the instructions in EX, MEM and WB. From that it generates the IF/ID stall, the ID/EX bubble and the ID flush, plus registered forwarding selects for the EX operands. It sits beside the ID/EX register and drives its hold and bubble controls and the EX operand muxes.

## Interface
- `REG_AW`, 3: register address width (8 architectural registers; x0 hardwired zero).
- `FLUSH_CYCLES`, 2: cycles of flush after a taken branch (1..7).

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `id_valid`  in  1  instruction in ID is valid.
- `id_rs1`, `id_rs2`  in  REG_AW  ID source registers.
- `id_rs2_used`  in  1  ID instruction reads rs2.
- `id_rd`  in  REG_AW  ID destination register.
- `id_write`  in  1  ID instruction writes `id_rd` (the writeReg control).
- `id_is_load`  in  1  ID instruction is a load.
- `ex_branch_taken`  in  1  branch in EX resolved taken.
- `stall_if`  out  1  hold PC and IF/ID this cycle.
- `bubble_ex`  out  1  load a bubble into ID/EX at the next edge: writeReg=0 and all fields 0.
- `flush_id`  out  1  invalidate IF/ID at the next edge.
- `fwd_a`, `fwd_b`  out  2  EX operand select: 00 register file, 01 EX/MEM result, 10 MEM/WB result.
- `state`  out  1  0=RUN, 1=FLUSH (debug).

## Operation
- Shadow slots EX, MEM and WB each hold {valid, rd, write, load}. A slot is "writing r" when valid & write & rd==r & r!=0.
- Shift at each clk edge:
  - MEM←EX and WB←MEM.
  - EX←{id_valid, id_rd, id_write, id_is_load} unless `bubble_ex`, in which case EX←0.
- FSM state RUN:
  - If `ex_branch_taken`: `flush_id`=1, `bubble_ex`=1, `stall_if`=0. Load counter with FLUSH_CYCLES-1. Go to FLUSH if FLUSH_CYCLES>1, else stay in RUN.
  - Else if a hazard exists and `id_valid`: `stall_if`=1, `bubble_ex`=1, `flush_id`=0.
  - Else all three are 0.
- FSM state FLUSH:
  - `flush_id`=1, `bubble_ex`=1, `stall_if`=0.
  - Counter decrements; at 0 go to RUN.
  - `ex_branch_taken` is ignored (EX holds only bubbles).
- Priority: a taken branch beats a hazard stall. The stalled ID instruction is wrong-path and is flushed.
- Forwarding (registered): at each edge where ID advances (no bubble), compute from pre-edge slots:
  - `fwd_a`=01 if the EX slot is writing id_rs1; else 10 if the MEM slot is writing id_rs1; else 00.
  - `fwd_b` is the same for id_rs2, forced to 00 when !id_rs2_used.
  - On a bubble edge, `fwd_a`/`fwd_b`←00.
- x0 never causes a hazard or a forward.
- Reset (async): all slots 0, state RUN, counter 0, `fwd_a`/`fwd_b`=00. `stall_if`/`bubble_ex`/`flush_id` are 0 while reset is held. Reset mid-flush aborts the flush.

## Timing
- `stall_if`, `bubble_ex` and `flush_id` are combinational from the inputs, slots and state, valid in the same cycle.
- `fwd_a` and `fwd_b` are registered. They are valid during the cycle the instruction occupies EX, i.e. one cycle after it was in ID.
- A load-use hazard costs exactly 1 stall cycle with forwarding.
- A taken branch costs FLUSH_CYCLES bubble cycles.
- Hazards with back-to-back loads are re-evaluated every cycle. A stall lasts as long as the condition holds.

## Configuration
- Macro `ID_EX_HAZARD_FWD_EN`.
- Defined:
  - Hazard = the EX slot is a load writing id_rs1, or writing id_rs2 when id_rs2_used.
  - Forwarding selects are computed as above.
- Undefined:
  - No forwarding; `fwd_a`/`fwd_b` are tied to 00.
  - Hazard = any of the EX, MEM or WB slots writing a used source. A dependent instruction stalls until the producer leaves WB, up to 3 cycles.

## Test plan
- Reset mid-FLUSH (FLUSH_CYCLES=3, reset after 1 flush cycle) → next cycle state=0 and all outputs 0; the following independent instruction proceeds with no bubble.
- `add x1,...` then `add x2,x1,x3` (FWD_EN) → no stall; `fwd_a`=01 in the consumer's EX cycle. With one independent instruction between them → `fwd_a`=10.
- `lw x4` then `add x5,x4,x4` (FWD_EN) → exactly 1 cycle of `stall_if`=1/`bubble_ex`=1; then `fwd_a`=`fwd_b`=10.
- Same dependent pair without FWD_EN → 3 stall cycles; `fwd_*` stays 00.
- Write to x0 followed by a read of x0 → no stall; `fwd_a`=00.
- `ex_branch_taken`=1 coincident with a load-use hazard → `flush_id`=1, `stall_if`=0. With FLUSH_CYCLES=2 there are 2 flush cycles, `state`=1 for one cycle, then RUN.
